// File: rtl/rx_rate_meter.sv
// rx_rate_meter
//   Per-channel receive-rate meter. Over a window of WINDOW clk125MHz cycles it
//   counts data-valid bytes, completed frames and errored frames on each of NCH
//   channels. At the end of every window it copies the counts into stable
//   output registers, pulses snap_valid, and tracks the peak byte count.
//   All counters saturate at all-ones instead of wrapping.
//
// Ports
//   clk125MHz  : sole clock, rising edge
//   rstn       : asynchronous active-low reset, clears every register
//   clr        : synchronous clear of window, accumulators, err flags, outputs, peak
//   rx_en      : [NCH] per-channel byte valid
//   rx_err     : [NCH] per-channel error flag, only meaningful while rx_en is high
//   byte_rate  : [NCH*CNT_W] bytes in last complete window, ch i at [i*CNT_W +: CNT_W]
//   frame_rate : [NCH*CNT_W] frames that ended in last window
//   err_rate   : [NCH*CNT_W] errored frames that ended in last window
//   peak_rate  : [NCH*CNT_W] largest byte_rate snapshot since reset/clr
//   snap_valid : one-cycle pulse, high the cycle after the outputs update
//   win_cnt    : [CNT_W] current position in the window, 0..WINDOW-1

module rx_rate_meter #(
    parameter int NCH    = 2,
    parameter int CNT_W  = 32,
    parameter int WINDOW = 125000000
) (
    input  logic                 clk125MHz,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic [NCH-1:0]       rx_en,
    input  logic [NCH-1:0]       rx_err,
    output logic [NCH*CNT_W-1:0] byte_rate,
    output logic [NCH*CNT_W-1:0] frame_rate,
    output logic [NCH*CNT_W-1:0] err_rate,
    output logic [NCH*CNT_W-1:0] peak_rate,
    output logic                 snap_valid,
    output logic [CNT_W-1:0]     win_cnt
);

    // The window counter is kept wide enough to hold WINDOW-1 even when the
    // count fields are narrower than the window; win_cnt shows its low bits.
    localparam int WIN_BITS = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WIN_W    = (WIN_BITS > CNT_W) ? WIN_BITS : CNT_W;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment: holds at all-ones, never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (inc && (v != CNT_MAX))
            return v + CNT_ONE;
        return v;
    endfunction

    logic [WIN_W-1:0] win_q;
    logic             snap_q;
    logic             end_cycle;

    assign end_cycle  = (win_q == WIN_LAST);
    assign win_cnt    = win_q[CNT_W-1:0];
    assign snap_valid = snap_q;

    // Window position and snapshot strobe
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            win_q  <= '0;
            snap_q <= 1'b0;
        end else if (clr) begin
            win_q  <= '0;
            snap_q <= 1'b0;
        end else begin
            win_q  <= end_cycle ? '0 : win_q + WIN_ONE;
            snap_q <= end_cycle;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] byte_acc;
        logic [CNT_W-1:0] frame_acc;
        logic [CNT_W-1:0] err_acc;
        logic [CNT_W-1:0] byte_out;
        logic [CNT_W-1:0] frame_out;
        logic [CNT_W-1:0] err_out;
        logic [CNT_W-1:0] peak_out;
        logic [CNT_W-1:0] byte_nxt;
        logic [CNT_W-1:0] frame_nxt;
        logic [CNT_W-1:0] err_nxt;
        logic             en_d;
        logic             err_flag;
        logic             frame_end;
        logic             err_set;

        // A frame ends on the first idle cycle after a run of valid bytes.
        assign err_set   = rx_en[i] & rx_err[i];
        assign frame_end = en_d & ~rx_en[i];

        assign byte_nxt  = sat_inc(byte_acc,  rx_en[i]);
        assign frame_nxt = sat_inc(frame_acc, frame_end);
        assign err_nxt   = sat_inc(err_acc,   frame_end & (err_flag | err_set));

        // Accumulate, and at the window end snapshot including this cycle's
        // increment while the accumulators restart from zero. en_d and
        // err_flag deliberately survive the window boundary so a frame that
        // straddles it is counted where it ends.
        always_ff @(posedge clk125MHz or negedge rstn) begin
            if (!rstn) begin
                en_d      <= 1'b0;
                err_flag  <= 1'b0;
                byte_acc  <= '0;
                frame_acc <= '0;
                err_acc   <= '0;
                byte_out  <= '0;
                frame_out <= '0;
                err_out   <= '0;
                peak_out  <= '0;
            end else if (clr) begin
                en_d      <= 1'b0;
                err_flag  <= 1'b0;
                byte_acc  <= '0;
                frame_acc <= '0;
                err_acc   <= '0;
                byte_out  <= '0;
                frame_out <= '0;
                err_out   <= '0;
                peak_out  <= '0;
            end else begin
                en_d     <= rx_en[i];
                err_flag <= (err_flag | err_set) & ~frame_end;
                if (end_cycle) begin
                    byte_out  <= byte_nxt;
                    frame_out <= frame_nxt;
                    err_out   <= err_nxt;
                    byte_acc  <= '0;
                    frame_acc <= '0;
                    err_acc   <= '0;
                    if (byte_nxt > peak_out)
                        peak_out <= byte_nxt;
                end else begin
                    byte_acc  <= byte_nxt;
                    frame_acc <= frame_nxt;
                    err_acc   <= err_nxt;
                end
            end
        end

        assign byte_rate [i*CNT_W +: CNT_W] = byte_out;
        assign frame_rate[i*CNT_W +: CNT_W] = frame_out;
        assign err_rate  [i*CNT_W +: CNT_W] = err_out;
        assign peak_rate [i*CNT_W +: CNT_W] = peak_out;
    end

endmodule
